regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/riscblade_wb_pkg.sv | 12 +
 rtl/rr_arb2.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscblade_wb_pkg.sv
// Shared writeback definitions: default register-file geometry and the requester id.
package riscblade_wb_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last requester granted.
// Handshake: a transfer happens when valid && ready; ready is combinational from valid and the pointer.
module rr_arb2
   import riscblade_wb_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    a_valid,
   input  logic    b_valid,
   output logic    a_ready,
   output logic    b_ready,
   output req_id_e o_last_grant
);

   req_id_e r_last;
   logic    w_pick_a;

   // A wins when alone, or on a conflict when B was served most recently.
   assign w_pick_a = a_valid & (~b_valid | (r_last == REQ_B));

   assign a_ready      = rst_n & w_pick_a;
   assign b_ready      = rst_n & b_valid & ~w_pick_a;
   assign o_last_grant = r_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last <= REQ_B;
      end else if (a_ready) begin
         r_last <= REQ_A;
      end else if (b_ready) begin
         r_last <= REQ_B;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Optional macro REGFILE_WB_BYPASS_EN forwards the in-flight write onto the read operands.
module regfile_wb_arbiter
   import riscblade_wb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              A_VALID,
   output logic              A_READY,
   input  logic [ADDR_W-1:0] A_RD,
   input  logic [DATA_W-1:0] A_DATA,
   input  logic              B_VALID,
   output logic              B_READY,
   input  logic [ADDR_W-1:0] B_RD,
   input  logic [DATA_W-1:0] B_DATA,
   output logic [ADDR_W-1:0] RF_RD,
   output logic [DATA_W-1:0] RF_REGDATA,
   output logic              RF_REGWRITE,
   input  logic [ADDR_W-1:0] RS1,
   input  logic [ADDR_W-1:0] RS2,
   input  logic [DATA_W-1:0] RF_REG_A,
   input  logic [DATA_W-1:0] RF_REG_B,
   output logic [DATA_W-1:0] REG_A,
   output logic [DATA_W-1:0] REG_B,
   output logic [CNT_W-1:0]  CONFLICT_CNT
);

   logic              w_a_xfer;
   logic              w_b_xfer;
   req_id_e           w_last_grant;
   logic              r_regwrite;
   logic [ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_cnt;

   rr_arb2 u_arb (
      .clk          (CLK),
      .rst_n        (RST_N),
      .a_valid      (A_VALID),
      .b_valid      (B_VALID),
      .a_ready      (A_READY),
      .b_ready      (B_READY),
      .o_last_grant (w_last_grant)
   );

   assign w_a_xfer = A_VALID & A_READY;
   assign w_b_xfer = B_VALID & B_READY;

   // RD/DATA hold their last value when no transfer happens.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_regwrite <= 1'b0;
         r_rd       <= '0;
         r_data     <= '0;
      end else begin
         r_regwrite <= w_a_xfer | w_b_xfer;
         if (w_a_xfer) begin
            r_rd   <= A_RD;
            r_data <= A_DATA;
         end else if (w_b_xfer) begin
            r_rd   <= B_RD;
            r_data <= B_DATA;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_cnt <= '0;
      end else if (A_VALID && B_VALID && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign RF_REGWRITE  = r_regwrite;
   assign RF_RD        = r_rd;
   assign RF_REGDATA   = r_data;
   assign CONFLICT_CNT = r_cnt;

   // The pointer is only observed by debug probes at this level.
   logic w_unused_last;
   assign w_unused_last = w_last_grant;

`ifdef REGFILE_WB_BYPASS_EN
   assign REG_A = (r_regwrite && (r_rd == RS1)) ? r_data : RF_REG_A;
   assign REG_B = (r_regwrite && (r_rd == RS2)) ? r_data : RF_REG_B;
`else
   assign REG_A = RF_REG_A;
   assign REG_B = RF_REG_B;

   logic w_unused_rs;
   assign w_unused_rs = ^{RS1, RS2};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int CW = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_v = 1'b0, b_v = 1'b0;
   logic [AW-1:0] a_rd = '0, b_rd = '0, rs1 = '0, rs2 = '0;
   logic [DW-1:0] a_data = '0, b_data = '0, rf_reg_a = '0, rf_reg_b = '0;
   logic          a_ready, b_ready, rf_we;
   logic [AW-1:0] rf_rd;
   logic [DW-1:0] rf_data, reg_a, reg_b;
   logic [CW-1:0] cnt;

   int checks = 0;
   int errors = 0;

   // Behavioural model: who was served last, what sits on the write port, conflict tally.
   bit            m_known = 1'b0;
   bit            m_last_b = 1'b1;
   bit            m_we = 1'b0;
   logic [AW-1:0] m_rd = '0;
   logic [DW-1:0] m_data = '0;
   int            m_cnt = 0;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .CLK          (clk),
      .RST_N        (rst_n),
      .A_VALID      (a_v),
      .A_READY      (a_ready),
      .A_RD         (a_rd),
      .A_DATA       (a_data),
      .B_VALID      (b_v),
      .B_READY      (b_ready),
      .B_RD         (b_rd),
      .B_DATA       (b_data),
      .RF_RD        (rf_rd),
      .RF_REGDATA   (rf_data),
      .RF_REGWRITE  (rf_we),
      .RS1          (rs1),
      .RS2          (rs2),
      .RF_REG_A     (rf_reg_a),
      .RF_REG_B     (rf_reg_b),
      .REG_A        (reg_a),
      .REG_B        (reg_b),
      .CONFLICT_CNT (cnt)
   );

   always #5 clk = ~clk;

   // One clock: check everything at the falling edge, then advance the model across the rising edge.
   task automatic tick(output bit ga, output bit gb);
      logic [DW-1:0] exp_a, exp_b;
      @(negedge clk);
      if (!rst_n) begin
         ga = 1'b0; gb = 1'b0;
      end else if (a_v && b_v) begin
         ga = m_last_b; gb = !m_last_b;
      end else begin
         ga = a_v; gb = b_v;
      end
`ifdef REGFILE_WB_BYPASS_EN
      exp_a = (m_we && m_rd == rs1) ? m_data : rf_reg_a;
      exp_b = (m_we && m_rd == rs2) ? m_data : rf_reg_b;
`else
      exp_a = rf_reg_a;
      exp_b = rf_reg_b;
`endif
      checks++;
      if (a_ready !== ga) begin errors++; $display("FAIL a_ready got=%b exp=%b t=%0t", a_ready, ga, $time); end
      checks++;
      if (b_ready !== gb) begin errors++; $display("FAIL b_ready got=%b exp=%b t=%0t", b_ready, gb, $time); end
      checks++;
      if (reg_a !== exp_a) begin errors++; $display("FAIL reg_a got=%0d exp=%0d t=%0t", reg_a, exp_a, $time); end
      checks++;
      if (reg_b !== exp_b) begin errors++; $display("FAIL reg_b got=%0d exp=%0d t=%0t", reg_b, exp_b, $time); end
      if (m_known) begin
         checks++;
         if (rf_we !== m_we) begin errors++; $display("FAIL rf_regwrite got=%b exp=%b t=%0t", rf_we, m_we, $time); end
         checks++;
         if (rf_rd !== m_rd) begin errors++; $display("FAIL rf_rd got=%0d exp=%0d t=%0t", rf_rd, m_rd, $time); end
         checks++;
         if (rf_data !== m_data) begin errors++; $display("FAIL rf_regdata got=%0d exp=%0d t=%0t", rf_data, m_data, $time); end
         checks++;
         if (cnt !== CW'(m_cnt)) begin errors++; $display("FAIL conflict_cnt got=%0d exp=%0d t=%0t", cnt, m_cnt, $time); end
      end
      @(posedge clk);
      if (!rst_n) begin
         m_known = 1'b1; m_last_b = 1'b1; m_we = 1'b0; m_rd = '0; m_data = '0; m_cnt = 0;
      end else begin
         if (a_v && b_v) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
         m_we = ga | gb;
         if (ga) begin m_rd = a_rd; m_data = a_data; m_last_b = 1'b0; end
         else if (gb) begin m_rd = b_rd; m_data = b_data; m_last_b = 1'b1; end
      end
      #1;
   endtask

   task automatic do_reset();
      bit ga, gb;
      rst_n = 1'b0;
      tick(ga, gb);
      tick(ga, gb);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bit ga, gb;
      a_v = 1'b1; b_v = 1'b1; a_rd = 4'd5; b_rd = 4'd6; a_data = 16'd11; b_data = 16'd22;
      rst_n = 1'b0;
      tick(ga, gb);
      tick(ga, gb);
      checks++;
      if (rf_we !== 1'b0 || rf_rd !== '0 || rf_data !== '0 || cnt !== '0) begin
         errors++; $display("FAIL reset_state we=%b rd=%0d data=%0d cnt=%0d exp all 0", rf_we, rf_rd, rf_data, cnt);
      end
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready a=%b b=%b exp 0 0", a_ready, b_ready);
      end
      a_v = 1'b0; b_v = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_a_only();
      bit ga, gb;
      do_reset();
      a_v = 1'b1; a_rd = 4'd1; a_data = 16'd50;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++; $display("FAIL a_only_ready a=%b b=%b exp 1 0", a_ready, b_ready);
      end
      tick(ga, gb);
      a_v = 1'b0;
      checks++;
      if (rf_we !== 1'b1 || rf_rd !== 4'd1 || rf_data !== 16'd50) begin
         errors++; $display("FAIL a_only_write we=%b rd=%0d data=%0d exp 1 1 50", rf_we, rf_rd, rf_data);
      end
      tick(ga, gb);
      checks++;
      if (rf_we !== 1'b0 || rf_rd !== 4'd1 || rf_data !== 16'd50) begin
         errors++; $display("FAIL idle_hold we=%b rd=%0d data=%0d exp 0 1 50", rf_we, rf_rd, rf_data);
      end
   endtask

   task automatic test_conflict();
      bit ga, gb;
      do_reset();
      a_v = 1'b1; a_rd = 4'd2; a_data = 16'd75;
      b_v = 1'b1; b_rd = 4'd3; b_data = 16'd90;
      tick(ga, gb);
      if (ga) a_v = 1'b0;
      checks++;
      if (rf_we !== 1'b1 || rf_rd !== 4'd2 || rf_data !== 16'd75) begin
         errors++; $display("FAIL conflict_first we=%b rd=%0d data=%0d exp 1 2 75", rf_we, rf_rd, rf_data);
      end
      tick(ga, gb);
      if (gb) b_v = 1'b0;
      checks++;
      if (rf_we !== 1'b1 || rf_rd !== 4'd3 || rf_data !== 16'd90) begin
         errors++; $display("FAIL conflict_second we=%b rd=%0d data=%0d exp 1 3 90", rf_we, rf_rd, rf_data);
      end
      checks++;
      if (cnt !== 8'd1) begin errors++; $display("FAIL conflict_cnt_one got=%0d exp=1", cnt); end
      tick(ga, gb);
   endtask

   task automatic test_same_rd();
      bit ga, gb;
      logic [DW-1:0] obs_q[$];
      do_reset();
      a_v = 1'b1; a_rd = 4'd0; a_data = 16'd75;
      b_v = 1'b1; b_rd = 4'd0; b_data = 16'd20;
      for (int i = 0; i < 4; i++) begin
         tick(ga, gb);
         if (ga) a_v = 1'b0;
         if (gb) b_v = 1'b0;
         if (rf_we === 1'b1) obs_q.push_back(rf_data);
      end
      checks++;
      if (obs_q.size() != 2) begin
         errors++; $display("FAIL same_rd_count got=%0d exp=2", obs_q.size());
      end else begin
         checks++;
         if (obs_q[0] !== 16'd75 || obs_q[1] !== 16'd20) begin
            errors++; $display("FAIL same_rd_order got=%0d,%0d exp=75,20", obs_q[0], obs_q[1]);
         end
      end
      checks++;
      if (rf_rd !== 4'd0 || rf_data !== 16'd20) begin
         errors++; $display("FAIL same_rd_final rd=%0d data=%0d exp 0 20", rf_rd, rf_data);
      end
   endtask

   task automatic test_bypass();
      bit ga, gb;
      logic [DW-1:0] exp_a;
      do_reset();
      a_v = 1'b1; a_rd = 4'd1; a_data = 16'd50;
      tick(ga, gb);
      a_v = 1'b0; rs1 = 4'd1; rf_reg_a = 16'd0; rs2 = 4'd7; rf_reg_b = 16'd33;
      #1;
`ifdef REGFILE_WB_BYPASS_EN
      exp_a = 16'd50;
`else
      exp_a = 16'd0;
`endif
      checks++;
      if (reg_a !== exp_a) begin errors++; $display("FAIL bypass_reg_a got=%0d exp=%0d", reg_a, exp_a); end
      checks++;
      if (reg_b !== 16'd33) begin errors++; $display("FAIL bypass_reg_b got=%0d exp=33", reg_b); end
      tick(ga, gb);
   endtask

   task automatic test_back_to_back();
      bit ga, gb;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         a_v = 1'b1; a_rd = AW'(i); a_data = DW'(100 + i);
         tick(ga, gb);
         checks++;
         if (rf_we !== 1'b1 || rf_data !== DW'(100 + i)) begin
            errors++; $display("FAIL back_to_back[%0d] we=%b data=%0d exp 1 %0d", i, rf_we, rf_data, 100 + i);
         end
      end
      a_v = 1'b0;
      tick(ga, gb);
   endtask

   task automatic test_saturation();
      bit ga, gb;
      do_reset();
      a_v = 1'b1; b_v = 1'b1; a_rd = 4'd4; b_rd = 4'd5; a_data = 16'd1; b_data = 16'd2;
      for (int i = 0; i < 300; i++) tick(ga, gb);
      checks++;
      if (cnt !== 8'd255) begin errors++; $display("FAIL saturate got=%0d exp=255", cnt); end
      tick(ga, gb);
      tick(ga, gb);
      checks++;
      if (cnt !== 8'd255) begin errors++; $display("FAIL saturate_hold got=%0d exp=255", cnt); end
      a_v = 1'b0; b_v = 1'b0;
      tick(ga, gb);
   endtask

   task automatic test_midstream_reset();
      bit ga, gb;
      do_reset();
      a_v = 1'b1; b_v = 1'b1; a_rd = 4'd8; b_rd = 4'd9; a_data = 16'd300; b_data = 16'd400;
      tick(ga, gb);
      tick(ga, gb);
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++; $display("FAIL midreset_ready a=%b b=%b exp 0 0", a_ready, b_ready);
      end
      tick(ga, gb);
      checks++;
      if (rf_we !== 1'b0 || rf_rd !== '0 || rf_data !== '0 || cnt !== '0) begin
         errors++; $display("FAIL midreset_state we=%b rd=%0d data=%0d cnt=%0d exp all 0", rf_we, rf_rd, rf_data, cnt);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++; $display("FAIL midreset_a_wins a=%b b=%b exp 1 0", a_ready, b_ready);
      end
      tick(ga, gb);
      a_v = 1'b0; b_v = 1'b0;
      tick(ga, gb);
   endtask

   task automatic test_random();
      bit ga, gb;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (!a_v && $urandom_range(0, 2) != 0) begin
            a_v = 1'b1; a_rd = AW'($urandom_range(0, 3)); a_data = DW'($urandom);
         end
         if (!b_v && $urandom_range(0, 2) != 0) begin
            b_v = 1'b1; b_rd = AW'($urandom_range(0, 3)); b_data = DW'($urandom);
         end
         rs1 = AW'($urandom_range(0, 3)); rs2 = AW'($urandom_range(0, 3));
         rf_reg_a = DW'($urandom); rf_reg_b = DW'($urandom);
         if (i == 200) rst_n = 1'b0;
         if (i == 202) rst_n = 1'b1;
         tick(ga, gb);
         if (ga) a_v = 1'b0;
         if (gb) b_v = 1'b0;
      end
      a_v = 1'b0; b_v = 1'b0;
      tick(ga, gb);
   endtask

   initial begin
      test_reset();
      test_a_only();
      test_conflict();
      test_same_rd();
      test_bypass();
      test_back_to_back();
      test_saturation();
      test_midstream_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
